// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every signal exchanged between the two pipeline requesters, the
// memory backend and the unified-memory port arbiter.
//
//   Requester side : if_req_p1, if_addr_p1, flush_if_p3,
//                    d_req_ixmem_p4, d_we_ixmem_p4, d_addr_ixmem_p4,
//                    d_wdata_ixmem_p4
//   Backend side   : mem_done, mem_rdata          (into the arbiter)
//                    mem_en, mem_we, mem_addr, mem_wdata (out of the arbiter)
//   Responses      : if_ack_p1, d_ack_p4, rdata, stall_if_p1, stall_mem_p4,
//                    err_arb
//
// Modports:
//   master - the environment (pipeline stages plus backend model)
//   slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req_p1;
  logic [ADDR_W-1:0] if_addr_p1;
  logic              flush_if_p3;
  logic              d_req_ixmem_p4;
  logic              d_we_ixmem_p4;
  logic [ADDR_W-1:0] d_addr_ixmem_p4;
  logic [DATA_W-1:0] d_wdata_ixmem_p4;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              if_ack_p1;
  logic              d_ack_p4;
  logic [DATA_W-1:0] rdata;
  logic              stall_if_p1;
  logic              stall_mem_p4;
  logic              err_arb;

  modport master (
    output if_req_p1, if_addr_p1, flush_if_p3,
    output d_req_ixmem_p4, d_we_ixmem_p4, d_addr_ixmem_p4, d_wdata_ixmem_p4,
    output mem_done, mem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  if_ack_p1, d_ack_p4, rdata, stall_if_p1, stall_mem_p4, err_arb
  );

  modport slave (
    input  if_req_p1, if_addr_p1, flush_if_p3,
    input  d_req_ixmem_p4, d_we_ixmem_p4, d_addr_ixmem_p4, d_wdata_ixmem_p4,
    input  mem_done, mem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output if_ack_p1, d_ack_p4, rdata, stall_if_p1, stall_mem_p4, err_arb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Sequences a single-ported unified instruction/data memory shared by the
// fetch stage (p1) and the mem stage (p4). One requester owns the port at a
// time; the arbiter issues a one-cycle strobe to the backend, waits for its
// completion pulse, registers the read data and acknowledges the owner.
// Fetch responses killed by a taken branch are discarded silently, and a
// backend that never completes parks the arbiter in a sticky error state.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave (requests, backend, acks, stalls, error)
//
// Parameters:
//   ADDR_W, DATA_W   - memory address / data width
//   TIMEOUT_CYCLES   - WAIT cycles tolerated before err_arb (>= 2)
//   MAX_DATA_BURST   - data grants allowed while fetch waits (fairness only)
//
// Optional feature: define ARB_FETCH_FAIR_EN to cap consecutive data grants
// while a fetch is pending. Without it, data always has priority.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              owner_if;     // 1 = fetch owns the port, 0 = data
  logic              discard;      // owning fetch was killed by a branch
  logic [TmoW-1:0]   tmo_cnt;
  logic              err_q;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              fetch_ok;
  logic              fair_pick;
  logic              grant_d;
  logic              grant_if;
  logic              in_flight;
  logic              mem_en_c;
  logic              if_ack_c;
  logic              d_ack_c;

  // A fetch whose branch is resolving this very cycle is stale; never grant it.
  assign fetch_ok  = bus.if_req_p1 & ~bus.flush_if_p3;
  assign in_flight = (state == S_ISSUE) | (state == S_WAIT);

`ifdef ARB_FETCH_FAIR_EN
  logic [2:0] burst_cnt;

  // Counts data grants that overtook a waiting fetch; saturates at 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (grant_if) begin
      burst_cnt <= '0;
    end else if (grant_d && bus.if_req_p1 && (burst_cnt != 3'd7)) begin
      burst_cnt <= burst_cnt + 3'd1;
    end
  end

  assign fair_pick = fetch_ok & (burst_cnt == 3'(MAX_DATA_BURST));
`else
  assign fair_pick = 1'b0;

  // MAX_DATA_BURST only matters when fairness is compiled in.
  logic unused_burst_cfg;
  assign unused_burst_cfg = (MAX_DATA_BURST != 0);
`endif

  // Grant selection, only ever evaluated in IDLE.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state == S_IDLE) begin
      if (fair_pick) begin
        grant_if = 1'b1;
      end else if (bus.d_req_ixmem_p4) begin
        grant_d = 1'b1;
      end else if (fetch_ok) begin
        grant_if = 1'b1;
      end
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nxt = state;
    mem_en_c  = 1'b0;
    if_ack_c  = 1'b0;
    d_ack_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_d || grant_if) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en_c  = 1'b1;
        state_nxt = bus.mem_done ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_done) begin
          state_nxt = S_RESP;
        end else if (tmo_cnt == TmoLast) begin
          state_nxt = S_ERR;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
        // A flush landing on the response cycle itself must still kill it.
        if (owner_if) begin
          if_ack_c = ~(discard | bus.flush_if_p3);
        end else begin
          d_ack_c = 1'b1;
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, ownership and backend request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner_if    <= 1'b0;
      discard     <= 1'b0;
      tmo_cnt     <= '0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state <= state_nxt;

      if (grant_d || grant_if) begin
        owner_if    <= grant_if;
        discard     <= 1'b0;
        mem_we_q    <= grant_d & bus.d_we_ixmem_p4;
        mem_addr_q  <= grant_d ? bus.d_addr_ixmem_p4 : bus.if_addr_p1;
        mem_wdata_q <= grant_d ? bus.d_wdata_ixmem_p4 : '0;
        tmo_cnt     <= '0;
      end else begin
        if (owner_if && bus.flush_if_p3 &&
            (in_flight || (state == S_RESP))) begin
          discard <= 1'b1;
        end
        if ((state == S_WAIT) && !bus.mem_done) begin
          tmo_cnt <= tmo_cnt + TmoW'(1);
        end
      end

      // Completions outside ISSUE/WAIT are stray and must not disturb rdata.
      if (in_flight && bus.mem_done) begin
        rdata_q <= bus.mem_rdata;
      end

      if ((state == S_WAIT) && !bus.mem_done && (tmo_cnt == TmoLast)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.mem_en       = mem_en_c;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.if_ack_p1    = if_ack_c;
  assign bus.d_ack_p4     = d_ack_c;
  assign bus.rdata        = rdata_q;
  assign bus.stall_if_p1  = bus.if_req_p1 & ~if_ack_c;
  assign bus.stall_mem_p4 = bus.d_req_ixmem_p4 & ~d_ack_c;
  assign bus.err_arb      = err_q;

endmodule
